// File: rtl/usb_word_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : usb_word_sequencer_if
// Description : Signal bundle between the 32-bit data side, the byte-wide
//               USB serializer/deserializer and usb_word_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_word_sequencer_if;
    // transmit side
    logic        output_ready;
    logic [31:0] average_data;
    logic        tx_ready;
    logic [7:0]  data_out;
    logic        shift_out;
    logic        tx_busy;
    // receive side
    logic        new_byte;
    logic [7:0]  data_in;
    logic [31:0] stock_data;
    logic        data_ready;
    logic        rx_error;

    // Environment side: word source, serializer and deserializer
    modport master (
        output output_ready, average_data, tx_ready, new_byte, data_in,
        input  data_out, shift_out, tx_busy, stock_data, data_ready, rx_error
    );

    // Sequencer side
    modport slave (
        input  output_ready, average_data, tx_ready, new_byte, data_in,
        output data_out, shift_out, tx_busy, stock_data, data_ready, rx_error
    );
endinterface
`default_nettype wire

// File: rtl/usb_word_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : usb_word_sequencer
// Description : Splits a 32-bit word into four MSB-first bytes for the USB
//               serializer and packs four received bytes into a 32-bit word,
//               discarding partial receive words that stall too long.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_word_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input wire                  clk,
    input wire                  n_rst,
    usb_word_sequencer_if.slave bus
);

    localparam logic [1:0]  TX_IDLE  = 2'd0;
    localparam logic [1:0]  TX_LOAD  = 2'd1;
    localparam logic [1:0]  TX_GAP   = 2'd2;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    logic [1:0]  tx_state_q, tx_state_d;
    logic [31:0] tx_word_q, tx_word_d;
    logic [1:0]  tx_idx_q, tx_idx_d;
    // A granted byte passes through one staging register before it is
    // published on data_out/shift_out, so every output comes from a flop.
    logic        emit_q, emit_d;
    logic [7:0]  emit_byte_q, emit_byte_d;
    logic        emit_last_q, emit_last_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        shift_out_q, shift_out_d;
    logic        tx_busy_q, tx_busy_d;
    logic [7:0]  w_cur_byte;

    // TX state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) tx_state_q <= TX_IDLE;
        else        tx_state_q <= tx_state_d;
    end

    // TX next-state logic; a new request waits until the last strobe retired
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: if (bus.output_ready && !tx_busy_q) tx_state_d = TX_LOAD;
            TX_LOAD: if (bus.tx_ready) tx_state_d = (tx_idx_q == 2'd3) ? TX_IDLE : TX_GAP;
            TX_GAP:  tx_state_d = TX_LOAD;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Select the current byte, MSB first
    always_comb begin
        w_cur_byte = tx_word_q[31:24];
        case (tx_idx_q)
            2'd0:    w_cur_byte = tx_word_q[31:24];
            2'd1:    w_cur_byte = tx_word_q[23:16];
            2'd2:    w_cur_byte = tx_word_q[15:8];
            default: w_cur_byte = tx_word_q[7:0];
        endcase
    end

    // TX output/datapath logic: capture, byte grant, strobe publication
    always_comb begin
        tx_word_d   = tx_word_q;
        tx_idx_d    = tx_idx_q;
        emit_d      = 1'b0;
        emit_byte_d = emit_byte_q;
        emit_last_d = 1'b0;
        data_out_d  = data_out_q;
        shift_out_d = 1'b0;
        tx_busy_d   = tx_busy_q;

        if (emit_q) begin
            data_out_d  = emit_byte_q;
            shift_out_d = 1'b1;
            if (emit_last_q) tx_busy_d = 1'b0;
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (bus.output_ready && !tx_busy_q) begin
                    tx_word_d = bus.average_data;
                    tx_idx_d  = 2'd0;
                    tx_busy_d = 1'b1;
                end
            end
            TX_LOAD: begin
                if (bus.tx_ready) begin
                    emit_d      = 1'b1;
                    emit_byte_d = w_cur_byte;
                    emit_last_d = (tx_idx_q == 2'd3);
                end
            end
            TX_GAP:  tx_idx_d = tx_idx_q + 2'd1;
            default: ;
        endcase
    end

    // TX datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_word_q   <= 32'h0;
            tx_idx_q    <= 2'd0;
            emit_q      <= 1'b0;
            emit_byte_q <= 8'h00;
            emit_last_q <= 1'b0;
            data_out_q  <= 8'h00;
            shift_out_q <= 1'b0;
            tx_busy_q   <= 1'b0;
        end else begin
            tx_word_q   <= tx_word_d;
            tx_idx_q    <= tx_idx_d;
            emit_q      <= emit_d;
            emit_byte_q <= emit_byte_d;
            emit_last_q <= emit_last_d;
            data_out_q  <= data_out_d;
            shift_out_q <= shift_out_d;
            tx_busy_q   <= tx_busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] rx_shift_q, rx_shift_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] stock_q, stock_d;
    logic        data_ready_q, data_ready_d;
    logic        rx_error_q, rx_error_d;

    // RX packing and stall timeout; an arriving byte always beats the timeout
    always_comb begin
        cnt_d        = cnt_q;
        rx_shift_d   = rx_shift_q;
        tmo_d        = tmo_q;
        stock_d      = stock_q;
        data_ready_d = 1'b0;
        rx_error_d   = 1'b0;
        if (bus.new_byte) begin
            tmo_d = 16'd0;
            if (cnt_q == 2'd3) begin
                stock_d      = {rx_shift_q, bus.data_in};
                data_ready_d = 1'b1;
                cnt_d        = 2'd0;
            end else begin
                rx_shift_d = {rx_shift_q[15:0], bus.data_in};
                cnt_d      = cnt_q + 2'd1;
            end
        end else if (cnt_q != 2'd0) begin
            if (tmo_q == TMO_LAST) begin
                cnt_d      = 2'd0;
                tmo_d      = 16'd0;
                rx_error_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    // RX registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q        <= 2'd0;
            rx_shift_q   <= 24'h0;
            tmo_q        <= 16'd0;
            stock_q      <= 32'h0;
            data_ready_q <= 1'b0;
            rx_error_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            rx_shift_q   <= rx_shift_d;
            tmo_q        <= tmo_d;
            stock_q      <= stock_d;
            data_ready_q <= data_ready_d;
            rx_error_q   <= rx_error_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.shift_out  = shift_out_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.stock_data = stock_q;
    assign bus.data_ready = data_ready_q;
    assign bus.rx_error   = rx_error_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_word_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_usb_word_sequencer
// Description : Self-checking bench for usb_word_sequencer with a
//               cycle-level reference model of byte/word timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_word_sequencer;

    localparam int T = 8;

    logic clk = 1'b0;
    logic n_rst;

    usb_word_sequencer_if bus ();

    usb_word_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;

    // reference model state
    bit          m_busy, m_active, m_pend, m_pend_last, m_shift, m_dr, m_err;
    logic [7:0]  m_pend_byte, m_dout;
    logic [31:0] m_word, m_acc, m_stock;
    int          m_idx, m_elig, m_cnt, m_last;

    // observation logs
    int         strobe_t[$];
    logic [7:0] strobe_b[$];
    int         dr_cnt  = 0;
    int         err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_active = 0; m_pend = 0; m_pend_last = 0; m_shift = 0;
        m_dr = 0; m_err = 0; m_pend_byte = 8'h00; m_dout = 8'h00;
        m_word = 32'h0; m_acc = 32'h0; m_stock = 32'h0;
        m_idx = 0; m_elig = 0; m_cnt = 0; m_last = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"},   bus.data_out,   32'h0);
        chk({tag, "_shift_out"},  bus.shift_out,  32'h0);
        chk({tag, "_tx_busy"},    bus.tx_busy,    32'h0);
        chk({tag, "_stock_data"}, bus.stock_data, 32'h0);
        chk({tag, "_data_ready"}, bus.data_ready, 32'h0);
        chk({tag, "_rx_error"},   bus.rx_error,   32'h0);
    endtask

    // One clock: advance the model with the sampled inputs, then compare.
    task automatic step();
        bit busy_prev, active_prev;
        @(posedge clk);
        t++;
        busy_prev   = m_busy;
        active_prev = m_active;
        m_shift = 0;
        if (m_pend) begin
            m_shift = 1;
            m_dout  = m_pend_byte;
            if (m_pend_last) m_busy = 0;
            m_pend = 0;
        end
        if (active_prev) begin
            if (t >= m_elig && bus.tx_ready) begin
                m_pend      = 1;
                m_pend_byte = m_word[31-8*m_idx -: 8];
                m_pend_last = (m_idx == 3);
                if (m_idx == 3) m_active = 0;
                else begin m_idx++; m_elig = t + 2; end
            end
        end else if (!busy_prev && bus.output_ready) begin
            m_active = 1; m_busy = 1; m_word = bus.average_data;
            m_idx = 0; m_elig = t + 1;
        end
        m_dr = 0; m_err = 0;
        if (bus.new_byte) begin
            m_acc = {m_acc[23:0], bus.data_in};
            m_cnt++;
            m_last = t;
            if (m_cnt == 4) begin m_stock = m_acc; m_dr = 1; m_cnt = 0; end
        end else if (m_cnt != 0 && t - m_last == T) begin
            m_err = 1; m_cnt = 0;
        end
        #1;
        chk("tx_busy",    bus.tx_busy,    m_busy);
        chk("shift_out",  bus.shift_out,  m_shift);
        chk("data_out",   bus.data_out,   m_dout);
        chk("stock_data", bus.stock_data, m_stock);
        chk("data_ready", bus.data_ready, m_dr);
        chk("rx_error",   bus.rx_error,   m_err);
        if (bus.shift_out) begin strobe_t.push_back(t); strobe_b.push_back(bus.data_out); end
        if (bus.data_ready) dr_cnt++;
        if (bus.rx_error)   err_cnt++;
        @(negedge clk);
    endtask

    task automatic cyc(input bit orq, input logic [31:0] ad, input bit tr,
                       input bit nb, input logic [7:0] din);
        bus.output_ready = orq;
        bus.average_data = ad;
        bus.tx_ready     = tr;
        bus.new_byte     = nb;
        bus.data_in      = din;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, $urandom, 1, 0, 8'($urandom));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic async_reset(input string tag);
        bus.output_ready = 0; bus.tx_ready = 1; bus.new_byte = 0;
        #2 n_rst = 1'b0;
        #1 chk_reset_outputs(tag);
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1;
        model_reset();
        #1 chk({tag, "_busy_after_release"}, bus.tx_busy, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k, base, dr0, err0, p;
        logic [31:0] w;
        logic [7:0]  rxb [4];
        int          gaps[4];

        n_rst = 1'b1;
        bus.output_ready = 0; bus.average_data = 0; bus.tx_ready = 1;
        bus.new_byte = 0; bus.data_in = 0;
        model_reset();
        async_reset("reset");

        // TX word, tx_ready held high
        strobe_t.delete(); strobe_b.delete();
        w = 32'hDEADBEEF;
        cyc(1, w, 1, 0, 8'h00);
        k = t;
        idle(10);
        chk("tx_nbytes", strobe_t.size(), 4);
        for (int i = 0; i < 4 && i < strobe_t.size(); i++) begin
            chk("tx_byte", strobe_b[i], w[31-8*i -: 8]);
            chk("tx_time", strobe_t[i], k + 2 + 2*i);
        end

        // Backpressure before byte 2 and an ignored mid-word request
        strobe_t.delete(); strobe_b.delete();
        w = 32'hCAFEF00D;
        cyc(1, w, 1, 0, 8'h00);
        k = t;
        for (int j = 1; j <= 16; j++)
            cyc(j == 5, 32'h12345678, !(j >= 3 && j <= 7), 0, 8'h00);
        chk("bp_nbytes", strobe_t.size(), 4);
        for (int i = 0; i < 4 && i < strobe_t.size(); i++)
            chk("bp_byte", strobe_b[i], w[31-8*i -: 8]);
        if (strobe_t.size() >= 2) chk("bp_delay", strobe_t[1], k + 9);

        // RX word with gaps under the timeout
        dr0 = dr_cnt;
        rxb = '{8'h01, 8'h23, 8'h45, 8'h67};
        gaps = '{1, 3, 6, 7};
        for (int i = 0; i < 4; i++) begin
            idle(gaps[i] - 1);
            cyc(0, 0, 1, 1, rxb[i]);
        end
        idle(3);
        chk("rx_word", bus.stock_data, 32'h01234567);
        chk("rx_pulses", dr_cnt - dr0, 1);

        // Timeout discards a partial word
        err0 = err_cnt;
        cyc(0, 0, 1, 1, 8'hAA);
        cyc(0, 0, 1, 1, 8'hBB);
        idle(10);
        chk("tmo_pulses", err_cnt - err0, 1);
        chk("tmo_stock", bus.stock_data, 32'h01234567);
        rxb = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, rxb[i]);
        idle(1);
        chk("tmo_recover", bus.stock_data, 32'h11223344);

        // Byte on the exact timeout cycle wins
        err0 = err_cnt;
        cyc(0, 0, 1, 1, 8'h55);
        idle(T - 1);
        cyc(0, 0, 1, 1, 8'h66);
        cyc(0, 0, 1, 1, 8'h77);
        cyc(0, 0, 1, 1, 8'h88);
        idle(2);
        chk("edge_no_error", err_cnt - err0, 0);
        chk("edge_word", bus.stock_data, 32'h55667788);

        // Concurrent TX and RX
        strobe_t.delete(); strobe_b.delete();
        w = 32'h0BADF00D;
        cyc(1, w, 1, 1, 8'hC0);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 1, 1, 8'hFF);
        cyc(0, 0, 1, 1, 8'hEE);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 1, 1, 8'h12);
        idle(6);
        chk("cc_rx", bus.stock_data, 32'hC0FFEE12);
        chk("cc_nbytes", strobe_t.size(), 4);
        for (int i = 0; i < 4 && i < strobe_t.size(); i++)
            chk("cc_byte", strobe_b[i], w[31-8*i -: 8]);

        // Reset mid-TX, right after byte 1 was strobed
        strobe_t.delete(); strobe_b.delete();
        cyc(1, 32'hA1B2C3D4, 1, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        chk("mid_first", strobe_t.size(), 1);
        base = strobe_t.size();
        async_reset("midreset");
        idle(12);
        chk("mid_no_more", strobe_t.size(), base);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            p = ((n / 200) % 2 == 0) ? 40 : 6;
            cyc($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0,
                $urandom_range(0, 99) < p, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
